// File: rtl/y1_hit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : y1_hit_monitor
// Purpose  : Watches the y1 matcher hit stream. It counts valid hits
//            (saturating at 255) and tracks the length of the current run of
//            consecutive valid hits (saturating at 15). When a run reaches
//            THRESH it raises alarm, which stays set until ack.
// Revision : 1.0 - initial release
// ============================================================================
module y1_hit_monitor #(
   parameter int THRESH = 4        // consecutive valid hits that raise alarm, 1..15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       hit,
   input  logic       ack,
   input  logic       clr,
   output logic       alarm,
   output logic [7:0] hit_count,
   output logic [3:0] run_len,
   output logic [1:0] state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_ALARM = 2'd2;

   localparam logic [3:0] C_THRESH  = 4'(THRESH);
   localparam logic [3:0] C_RUN_MAX = 4'd15;
   localparam logic [7:0] C_CNT_MAX = 8'd255;

   logic [1:0] state_q, state_d;
   logic [3:0] run_q,   run_d;
   logic [7:0] cnt_q,   cnt_d;
   logic       alarm_q, alarm_d;

   // A sample exists only when in_valid is high; gaps are neither hit nor miss.
   logic       w_hit_s;
   logic       w_miss_s;
   logic [3:0] w_run_inc;

   assign w_hit_s   = in_valid & hit;
   assign w_miss_s  = in_valid & ~hit;
   assign w_run_inc = (run_q == C_RUN_MAX) ? C_RUN_MAX : run_q + 4'd1;

   // Hit counter: clr wins over the old value but still counts a same-cycle hit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {7'd0, w_hit_s};
      end else if (w_hit_s && (cnt_q != C_CNT_MAX)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Run length: an ack from ALARM restarts the run, counting a same-cycle hit.
   always_comb begin
      run_d = run_q;
      if ((state_q == S_ALARM) && ack) begin
         run_d = w_hit_s ? 4'd1 : 4'd0;
      end else if ((state_q != S_IDLE) && (state_q != S_RUN) && (state_q != S_ALARM)) begin
         run_d = 4'd0;
      end else if (w_hit_s) begin
         run_d = w_run_inc;
      end else if (w_miss_s) begin
         run_d = 4'd0;
      end
   end

   // Next-state logic; threshold is compared against the updated run length.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (w_hit_s) begin
               state_d = (run_d == C_THRESH) ? S_ALARM : S_RUN;
            end
         end
         S_RUN: begin
            if (w_miss_s) begin
               state_d = S_IDLE;
            end else if (w_hit_s && (run_d == C_THRESH)) begin
               state_d = S_ALARM;
            end
         end
         S_ALARM: begin
            if (ack) begin
               if (w_hit_s) begin
                  state_d = (run_d == C_THRESH) ? S_ALARM : S_RUN;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode: alarm is registered alongside the state it mirrors.
   always_comb begin
      alarm_d = (state_d == S_ALARM);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         run_q   <= 4'd0;
         cnt_q   <= 8'd0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
      end
   end

   assign alarm     = alarm_q;
   assign hit_count = cnt_q;
   assign run_len   = run_q;
   assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_y1_hit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_y1_hit_monitor
// Purpose  : Scoreboard bench for y1_hit_monitor. Three instances (THRESH 4,
//            1 and 15) share one stimulus stream; a counting reference model
//            predicts each instance's outputs, and a monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y1_hit_monitor;

   typedef struct packed {
      logic       al;
      logic [7:0] hc;
      logic [3:0] rl;
      logic [1:0] st;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic hit = 1'b0;
   logic ack = 1'b0;
   logic clr = 1'b0;

   logic       al [3];
   logic [7:0] hc [3];
   logic [3:0] rl [3];
   logic [1:0] st [3];

   int checks = 0;
   int errors = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   // Reference model state: plain integer counters and an alarm flag.
   int c_thr [3] = '{4, 1, 15};
   int m_hc  [3];
   int m_run [3];
   bit m_al  [3];

   always #5 clk = ~clk;

   y1_hit_monitor #(.THRESH(4)) u_t4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .hit(hit), .ack(ack), .clr(clr),
      .alarm(al[0]), .hit_count(hc[0]), .run_len(rl[0]), .state(st[0]));

   y1_hit_monitor #(.THRESH(1)) u_t1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .hit(hit), .ack(ack), .clr(clr),
      .alarm(al[1]), .hit_count(hc[1]), .run_len(rl[1]), .state(st[1]));

   y1_hit_monitor #(.THRESH(15)) u_t15 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .hit(hit), .ack(ack), .clr(clr),
      .alarm(al[2]), .hit_count(hc[2]), .run_len(rl[2]), .state(st[2]));

   task automatic chk(input string nm, input int inst, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t got=%0h exp=%0h", nm, inst, $time, got, exp);
      end
   endtask

   task automatic chk_all(input int i, input exp_t e);
      chk("alarm",     i, {7'd0, al[i]}, {7'd0, e.al});
      chk("hit_count", i, hc[i],         e.hc);
      chk("run_len",   i, {4'd0, rl[i]}, {4'd0, e.rl});
      chk("state",     i, {6'd0, st[i]}, {6'd0, e.st});
   endtask

   // Apply one cycle of inputs, advance the model, and queue the expectations.
   task automatic drive(input bit r, input bit v, input bit h, input bit a, input bit c);
      exp_t e;
      @(negedge clk);
      rst = r; in_valid = v; hit = h; ack = a; clr = c;
      for (int i = 0; i < 3; i++) begin
         if (r) begin
            m_hc[i] = 0; m_run[i] = 0; m_al[i] = 1'b0;
         end else begin
            if (c)           m_hc[i] = (v && h) ? 1 : 0;
            else if (v && h) m_hc[i] = (m_hc[i] >= 255) ? 255 : m_hc[i] + 1;
            if (v)           m_run[i] = h ? ((m_run[i] >= 15) ? 15 : m_run[i] + 1) : 0;
            if (m_al[i] && a) begin
               m_al[i]  = 1'b0;
               m_run[i] = (v && h) ? 1 : 0;
            end
            if (!m_al[i] && v && h && (m_run[i] == c_thr[i])) m_al[i] = 1'b1;
         end
         e.al = m_al[i];
         e.hc = 8'(m_hc[i]);
         e.rl = 4'(m_run[i]);
         e.st = m_al[i] ? 2'd2 : ((m_run[i] > 0) ? 2'd1 : 2'd0);
         if (i == 0) q0.push_back(e);
         else if (i == 1) q1.push_back(e);
         else q2.push_back(e);
      end
   endtask

   task automatic hits(input int n);
      for (int k = 0; k < n; k++) drive(0, 1, 1, 0, 0);
   endtask

   // Monitor: every edge produces a fresh output set for each pending sample.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin e = q0.pop_front(); chk_all(0, e); end
         if (q1.size() > 0) begin e = q1.pop_front(); chk_all(1, e); end
         if (q2.size() > 0) begin e = q2.pop_front(); chk_all(2, e); end
      end
   end

   initial begin
      int guard;
      // Reset state
      drive(1, 1, 1, 1, 1);
      drive(1, 0, 0, 0, 0);
      // Four consecutive hits
      hits(4);
      // Hits across gaps, then a miss
      drive(1, 0, 0, 0, 0);
      hits(2);
      drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0); drive(0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0);
      drive(0, 1, 0, 0, 0);
      // Alarm, ack with hit, then ack while not alarmed, ack with gap
      drive(1, 0, 0, 0, 0);
      hits(4);
      drive(0, 1, 1, 1, 0);
      drive(0, 0, 0, 1, 0);
      drive(0, 1, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      hits(5);
      drive(0, 0, 0, 1, 0);
      // Long hit run: both counters saturate, then clr with hit at 255
      drive(1, 0, 0, 0, 0);
      hits(300);
      drive(0, 1, 1, 0, 1);
      drive(0, 0, 0, 0, 1);
      // clr with hit at 200
      drive(1, 0, 0, 0, 0);
      hits(200);
      drive(0, 1, 1, 0, 1);
      // Reset during alarm with run length 9
      drive(1, 0, 0, 0, 0);
      hits(9);
      drive(1, 1, 1, 1, 1);
      // Single hit from idle
      hits(1);
      drive(0, 1, 0, 0, 0);
      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         drive(($urandom % 150) == 0,
               ($urandom % 4) != 0,
               ($urandom % 5) != 0,
               ($urandom % 8) == 0,
               ($urandom % 60) == 0);
      end
      drive(0, 0, 0, 0, 0);
      guard = 0;
      while (((q0.size() + q1.size() + q2.size()) != 0) && (guard < 20)) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if ((q0.size() + q1.size() + q2.size()) != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required=0", q0.size() + q1.size() + q2.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
